// File: rtl/blastn_hit_scheduler_pkg.sv
// ============================================================================
// Module      : blastn_hit_scheduler_pkg
// Description : Shared message layouts, state encoding and helper functions
//               for the BLASTN hit scheduler, its control unit and the UGPE.
//               hit_msg_t       : {db_pos, q_pos, db_seq, q_seq}, 128 bits
//               sched_out_msg_t : {db_pos, q_pos, score},         96 bits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blastn_hit_scheduler_pkg;

  localparam int HIT_W   = 128;
  localparam int SCORE_W = 32;
  localparam int OUT_W   = 96;

  typedef struct packed {
    logic [31:0] db_pos;
    logic [31:0] q_pos;
    logic [31:0] db_seq;
    logic [31:0] q_seq;
  } hit_msg_t;

  typedef struct packed {
    logic [31:0] db_pos;
    logic [31:0] q_pos;
    logic [31:0] score;
  } sched_out_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } sched_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Two-character ASCII tag for line traces (I/IS/W/E).
  function automatic logic [15:0] state_tag(input sched_state_e s);
    case (s)
      ST_IDLE:  return "I ";
      ST_ISSUE: return "IS";
      ST_WAIT:  return "W ";
      default:  return "E ";
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/blastn_hit_scheduler_if.sv
// ============================================================================
// Module      : blastn_hit_scheduler_if
// Description : Handshake bundle of the hit scheduler.
//               req_*      : NREQ requester hits (slice i = bits 128*i+:128)
//               ext_req_*  : 128-bit hit towards the UGPE
//               ext_resp_* : 32-bit unsigned score back from the UGPE
//               out_*      : 96-bit surviving result plus requester id
//               master : scheduler side, slave : environment side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface blastn_hit_scheduler_if #(
  parameter int NREQ = 4
);
  import blastn_hit_scheduler_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_val;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*HIT_W-1:0] req_msg;

  logic                  ext_req_val;
  logic                  ext_req_rdy;
  logic [HIT_W-1:0]      ext_req_msg;

  logic                  ext_resp_val;
  logic                  ext_resp_rdy;
  logic [SCORE_W-1:0]    ext_resp_msg;

  logic                  out_val;
  logic                  out_rdy;
  logic [OUT_W-1:0]      out_msg;
  logic [IDW-1:0]        out_id;

  modport master (
    input  req_val, req_msg, ext_req_rdy, ext_resp_val, ext_resp_msg, out_rdy,
    output req_rdy, ext_req_val, ext_req_msg, ext_resp_rdy, out_val, out_msg, out_id
  );

  modport slave (
    output req_val, req_msg, ext_req_rdy, ext_resp_val, ext_resp_msg, out_rdy,
    input  req_rdy, ext_req_val, ext_req_msg, ext_resp_rdy, out_val, out_msg, out_id
  );

endinterface

`default_nettype wire

// File: rtl/blastn_hit_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : blastn_hit_scheduler_rr_arbiter
// Description : Round-robin arbiter. Grants the first asserted request at or
//               after the pointer, wrapping modulo NREQ. The pointer moves to
//               (grant+1) mod NREQ only when a grant is issued while enabled.
// Ports       : clk, reset     - clock, asynchronous active-high reset
//               req_i          - request vector
//               en_i           - grant enable
//               gnt_o          - one-hot grant (zero when disabled/idle)
//               gnt_idx_o      - index of the winning request
//               gnt_val_o      - a grant is issued this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blastn_hit_scheduler_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_val_o
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW:0]   cand;
  logic [IDW:0]   nxt;
  logic [IDW-1:0] idx;
  logic           found;

  // Scan NREQ positions starting at the pointer; one extra bit on the
  // candidate lets the wrap be done with a single conditional subtract.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(off);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && req_i[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    nxt   = {1'b0, idx} + {{IDW{1'b0}}, 1'b1};
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (nxt == NREQ_W) ? '0 : nxt[IDW-1:0];
    end
  end

  always_comb begin
    gnt_o = '0;
    if (en_i && found) begin
      gnt_o[idx] = 1'b1;
    end
  end

  assign gnt_idx_o = idx;
  assign gnt_val_o = en_i & found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/blastn_hit_scheduler.sv
// ============================================================================
// Module      : blastn_hit_scheduler
// Description : Shares one ungapped-extension engine (UGPE) between NREQ
//               seed-hit requesters. Round-robin picks a hit, sends it to
//               the UGPE, waits for the score and forwards the hit with its
//               requester id only if score >= threshold latched at grant.
//               One extension outstanding at a time.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               bus (master)      - req_*, ext_req_*, ext_resp_*, out_*
//               cfg_threshold_i   - minimum forwarded score (unsigned)
//               busy_o            - high in any state other than IDLE
//               stat_issued_o     - saturating count of hits sent to UGPE
//               stat_dropped_o    - saturating count of below-threshold hits
// Options     : BLASTN_HIT_SCHED_STATS_EN - when defined the two stat ports
//               are live counters; otherwise they are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blastn_hit_scheduler
  import blastn_hit_scheduler_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  blastn_hit_scheduler_if.master    bus,
  input  logic [31:0]               cfg_threshold_i,
  output logic                      busy_o,
  output logic [31:0]               stat_issued_o,
  output logic [31:0]               stat_dropped_o
);

  sched_state_e   state_q;
  hit_msg_t       hit_q;
  hit_msg_t       hit_sel;
  logic [IDW-1:0] id_q;
  logic [31:0]    thr_q;
  logic [31:0]    score_q;
  logic           ext_req_val_q;
  logic           ext_resp_rdy_q;
  logic           out_val_q;
  logic           busy_q;

  logic            arb_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_val;
  logic            score_pass;
  sched_out_msg_t  out_m;

  // Gating with reset keeps req_rdy low while reset is held, not just
  // after the state register has cleared.
  assign arb_en = (state_q == ST_IDLE) && !reset;

  blastn_hit_scheduler_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (bus.req_val),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_val_o (gnt_val)
  );

  always_comb begin
    hit_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        hit_sel = bus.req_msg[HIT_W*i +: HIT_W];
      end
    end
  end

  // Compared against the threshold captured at grant, so reprogramming
  // cfg_threshold_i never affects the hit already in flight.
  assign score_pass = (bus.ext_resp_msg >= thr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      hit_q          <= '0;
      id_q           <= '0;
      thr_q          <= '0;
      score_q        <= '0;
      ext_req_val_q  <= 1'b0;
      ext_resp_rdy_q <= 1'b0;
      out_val_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_val) begin
            hit_q         <= hit_sel;
            id_q          <= gnt_idx;
            thr_q         <= cfg_threshold_i;
            ext_req_val_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.ext_req_rdy) begin
            ext_req_val_q  <= 1'b0;
            ext_resp_rdy_q <= 1'b1;
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.ext_resp_val) begin
            score_q        <= bus.ext_resp_msg;
            ext_resp_rdy_q <= 1'b0;
            if (score_pass) begin
              out_val_q <= 1'b1;
              state_q   <= ST_EMIT;
            end else begin
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_EMIT: begin
          if (bus.out_rdy) begin
            out_val_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_m        = '0;
    out_m.db_pos = hit_q.db_pos;
    out_m.q_pos  = hit_q.q_pos;
    out_m.score  = score_q;
  end

  assign bus.req_rdy      = gnt;
  assign bus.ext_req_val  = ext_req_val_q;
  assign bus.ext_req_msg  = ext_req_val_q ? hit_q : '0;
  assign bus.ext_resp_rdy = ext_resp_rdy_q;
  assign bus.out_val      = out_val_q;
  assign bus.out_msg      = out_val_q ? out_m : '0;
  assign bus.out_id       = out_val_q ? id_q : '0;
  assign busy_o           = busy_q;

`ifdef BLASTN_HIT_SCHED_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_q  <= '0;
      stat_dropped_q <= '0;
    end else begin
      if ((state_q == ST_ISSUE) && bus.ext_req_rdy) begin
        stat_issued_q <= sat_inc(stat_issued_q);
      end
      if ((state_q == ST_WAIT) && bus.ext_resp_val && !score_pass) begin
        stat_dropped_q <= sat_inc(stat_dropped_q);
      end
    end
  end

  assign stat_issued_o  = stat_issued_q;
  assign stat_dropped_o = stat_dropped_q;
`else
  assign stat_issued_o  = '0;
  assign stat_dropped_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_blastn_hit_scheduler.sv
// ============================================================================
// Module      : tb_blastn_hit_scheduler
// Description : Self-checking bench for blastn_hit_scheduler. A small
//               reference model (round-robin pointer, pending-hit table,
//               issue/drop tallies) predicts every grant and output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blastn_hit_scheduler;
  import blastn_hit_scheduler_pkg::*;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cfg_threshold = '0;
  logic        busy;
  logic [31:0] stat_issued;
  logic [31:0] stat_dropped;

  blastn_hit_scheduler_if #(.NREQ(NREQ)) bus ();

  blastn_hit_scheduler #(.NREQ(NREQ)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .cfg_threshold_i (cfg_threshold),
    .busy_o          (busy),
    .stat_issued_o   (stat_issued),
    .stat_dropped_o  (stat_dropped)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int              ptr_m = 0;
  logic [127:0]    hit_m [NREQ];
  logic [NREQ-1:0] val_m = '0;
  int              issued_m = 0;
  int              dropped_m = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant();
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ptr_m + k) % NREQ;
      if (val_m[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_stat(input int v);
`ifdef BLASTN_HIT_SCHED_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic load(input int i);
    hit_m[i] = {$urandom, $urandom, $urandom, $urandom};
    val_m[i] = 1'b1;
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < NREQ; i++) bus.req_msg[128*i +: 128] = hit_m[i];
    bus.req_val = val_m;
  endtask

  // One complete hit transaction from IDLE; g returns the grant seen on req_rdy.
  task automatic xact(input logic [31:0] score, input int req_stall, input int out_stall,
                      input bit chg_thr, input logic [31:0] new_thr, input bit reload,
                      output int g);
    logic [127:0] h;
    logic [31:0]  thr;
    logic [95:0]  exp_out;
    int           ge;
    apply_reqs();
    #1;
    ge = next_grant();
    g = -1;
    for (int k = 0; k < NREQ; k++) if (bus.req_rdy[k]) g = k;
    check("idle_busy", busy, 0);
    check("grant_onehot", bus.req_rdy, (ge < 0) ? 0 : (1 << ge));
    if (ge < 0) return;
    h = hit_m[ge];
    thr = cfg_threshold;
    ptr_m = (ge + 1) % NREQ;
    @(negedge clk);
    val_m[ge] = 1'b0;
    if (reload) load(ge);
    apply_reqs();
    for (int s = 0; s <= req_stall; s++) begin
      bus.ext_req_rdy = (s == req_stall);
      #1;
      check("issue_val", bus.ext_req_val, 1);
      check("issue_msg", bus.ext_req_msg, h);
      check("issue_no_req_rdy", bus.req_rdy, 0);
      @(negedge clk);
    end
    bus.ext_req_rdy = 1'b0;
    issued_m++;
    if (chg_thr) cfg_threshold = new_thr;
    #1;
    check("wait_resp_rdy", bus.ext_resp_rdy, 1);
    check("wait_req_msg", bus.ext_req_msg, 0);
    check("wait_out_val", bus.out_val, 0);
    check("stat_issued", stat_issued, exp_stat(issued_m));
    @(negedge clk);
    bus.ext_resp_val = 1'b1;
    bus.ext_resp_msg = score;
    #1;
    check("wait_resp_rdy2", bus.ext_resp_rdy, 1);
    @(negedge clk);
    bus.ext_resp_val = 1'b0;
    bus.ext_resp_msg = $urandom;
    if (score >= thr) begin
      exp_out = {h[127:96], h[95:64], score};
      for (int s = 0; s <= out_stall; s++) begin
        bus.out_rdy = (s == out_stall);
        #1;
        check("emit_val", bus.out_val, 1);
        check("emit_msg", bus.out_msg, exp_out);
        check("emit_id", bus.out_id, ge);
        check("emit_no_req_rdy", bus.req_rdy, 0);
        check("emit_resp_rdy", bus.ext_resp_rdy, 0);
        @(negedge clk);
      end
      bus.out_rdy = 1'b0;
    end else begin
      dropped_m++;
      #1;
      check("drop_no_out", bus.out_val, 0);
      check("drop_out_msg", bus.out_msg, 0);
    end
    check("done_busy", busy, 0);
    check("stat_dropped", stat_dropped, exp_stat(dropped_m));
  endtask

  // Line trace: state tag, id and score on every state change.
  sched_state_e tr_prev = ST_IDLE;
  always @(posedge clk) begin
    #2;
    if (dut.state_q !== tr_prev) begin
      $display("trace %s id=%0d score=%0d", state_tag(dut.state_q), dut.id_q, dut.score_q);
      tr_prev = dut.state_q;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req_val = '0;
    bus.req_msg = '0;
    bus.ext_req_rdy = 1'b0;
    bus.ext_resp_val = 1'b0;
    bus.ext_resp_msg = '0;
    bus.out_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) hit_m[i] = '0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_ext_req_val", bus.ext_req_val, 0);
    check("rst_ext_req_msg", bus.ext_req_msg, 0);
    check("rst_resp_rdy", bus.ext_resp_rdy, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_msg", bus.out_msg, 0);
    check("rst_out_id", bus.out_id, 0);
    check("rst_stat_issued", stat_issued, 0);
    check("rst_stat_dropped", stat_dropped, 0);
    @(negedge clk);

    // All four requesters valid from pointer 0; req 0 re-arms after its grant
    for (int i = 0; i < NREQ; i++) load(i);
    xact(32'd7, 0, 0, 1'b0, 32'd0, 1'b1, g); check("rr_order_0", g, 0);
    xact(32'd8, 0, 0, 1'b0, 32'd0, 1'b0, g); check("rr_order_1", g, 1);
    xact(32'd9, 0, 0, 1'b0, 32'd0, 1'b0, g); check("rr_order_2", g, 2);
    xact(32'd3, 0, 0, 1'b0, 32'd0, 1'b0, g); check("rr_order_3", g, 3);
    xact(32'd4, 0, 0, 1'b0, 32'd0, 1'b0, g); check("rr_req0_again", g, 0);

    // Single hit on req 0, threshold 10, score 25
    cfg_threshold = 32'd10;
    load(0);
    xact(32'd25, 0, 0, 1'b0, 32'd0, 1'b0, g); check("single_grant", g, 0);

    // Threshold boundary: 99 dropped, 100 forwarded
    cfg_threshold = 32'd100;
    load(1);
    xact(32'd99, 0, 0, 1'b0, 32'd0, 1'b0, g);
    check("thr_dropped_cnt", stat_dropped, exp_stat(1));
    load(1);
    xact(32'd100, 0, 0, 1'b0, 32'd0, 1'b0, g);

    // Backpressure with another requester waiting
    cfg_threshold = 32'd0;
    load(2);
    load(3);
    xact(32'd5, 5, 3, 1'b0, 32'd0, 1'b0, g); check("bp_grant", g, 2);
    xact(32'd6, 0, 0, 1'b0, 32'd0, 1'b0, g); check("bp_next", g, 3);

    // Threshold moved 5 -> 200 while waiting; latched 5 applies
    cfg_threshold = 32'd5;
    load(0);
    xact(32'd50, 0, 0, 1'b1, 32'd200, 1'b0, g);

    // Randomized traffic
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < NREQ; k++) if (!val_m[k] && ($urandom_range(1, 0) == 1)) load(k);
      if (val_m == '0) load(int'($urandom_range(NREQ-1, 0)));
      cfg_threshold = $urandom_range(200, 0);
      xact($urandom_range(250, 0), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)), $urandom_range(200, 0), 1'($urandom_range(1, 0)), g);
    end
    repeat (NREQ) if (val_m != '0) xact($urandom_range(250, 0), 0, 0, 1'b0, 32'd0, 1'b0, g);

    // Asynchronous reset during WAIT
    cfg_threshold = 32'd0;
    load(1);
    apply_reqs();
    #1;
    check("rst_t_grant", bus.req_rdy, 1 << next_grant());
    @(negedge clk);
    val_m[1] = 1'b0;
    apply_reqs();
    bus.ext_req_rdy = 1'b1;
    #1;
    check("rst_t_issue", bus.ext_req_val, 1);
    @(negedge clk);
    bus.ext_req_rdy = 1'b0;
    #1;
    check("rst_t_wait", bus.ext_resp_rdy, 1);
    load(2);
    apply_reqs();
    #1;
    reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_resp_rdy", bus.ext_resp_rdy, 0);
    check("async_req_rdy", bus.req_rdy, 0);
    check("async_ext_req_val", bus.ext_req_val, 0);
    check("async_out_val", bus.out_val, 0);
    check("async_stat_issued", stat_issued, 0);
    check("async_stat_dropped", stat_dropped, 0);
    ptr_m = 0;
    issued_m = 0;
    dropped_m = 0;
    @(negedge clk);
    reset = 1'b0;
    xact(32'd77, 0, 0, 1'b0, 32'd0, 1'b0, g); check("post_rst_grant", g, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/blastn_hit_scheduler.md
Name: blastn_hit_scheduler

Overview:
Shares one ungapped-extension engine (UGPE) between NREQ seed-hit requesters.
- Round-robin arbitrates pending hits.
- Issues each winning hit to the engine as a 128-bit request and waits for the 32-bit score.
- Drops hits scoring below a configured threshold; forwards survivors with the requester id.
- Sits between the per-lane hit generators / control units and the UGPE; one extension outstanding at a time.

Parameters:
NREQ, 4, number of requesters (2..8).
IDW, $clog2(NREQ), requester id width (derived; not overridden).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_val  input  NREQ  per-requester hit valid
req_rdy  output  NREQ  per-requester hit accept (one-hot or zero)
req_msg  input  NREQ*128  per-requester hit, slice i = bits [128*i+127:128*i], packed {db_pos,q_pos,db_seq,q_seq}
cfg_threshold  input  32  minimum score to forward (unsigned)
ext_req_val  output  1  request to UGPE valid
ext_req_rdy  input  1  UGPE ready
ext_req_msg  output  128  hit forwarded unchanged
ext_resp_val  input  1  UGPE score valid
ext_resp_rdy  output  1  scheduler accepts score
ext_resp_msg  input  32  score, unsigned
out_val  output  1  surviving result valid
out_rdy  input  1  downstream ready
out_msg  output  96  {db_pos, q_pos, score}
out_id  output  IDW  requester index of out_msg
busy  output  1  high in any state other than IDLE
stat_issued  output  32  hits sent to UGPE
stat_dropped  output  32  hits below threshold

Behaviour:
- Single clock clk; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-extension) forces:
  - state IDLE;
  - rr pointer 0;
  - all registers 0;
  - all val/rdy outputs 0;
  - out_msg, out_id, ext_req_msg 0.
  A UGPE response in flight at reset is abandoned; UGPE is reset by the same signal.
- All msg outputs are masked to 0 while their val is low.
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - If any req_val, grant the first asserted index at or after the pointer, wrapping modulo NREQ.
  - req_rdy[grant]=1 combinationally in the same cycle.
  - Latch hit, grant id and cfg_threshold.
  - Pointer <= (grant+1) mod NREQ.
  - Next state ISSUE.
  - No req_val: stay in IDLE, all req_rdy=0.
- ISSUE:
  - ext_req_val=1 with the latched hit.
  - On ext_req_rdy -> WAIT; otherwise hold, with message stable.
- WAIT:
  - ext_resp_rdy=1.
  - On ext_resp_val, latch score.
  - If score >= latched threshold (unsigned, inclusive) -> EMIT.
  - Otherwise -> IDLE, stat_dropped+1.
- EMIT:
  - out_val=1 with out_msg={db_pos,q_pos,score} and out_id.
  - On out_rdy -> IDLE; otherwise hold, with message stable.
- Latency, best case with all rdy high:
  - hit accepted at cycle 0;
  - ext_req_val at cycle 1;
  - if ext_resp_val arrives at cycle k, out_val is asserted at k+1;
  - next grant possible one cycle after leaving EMIT (or WAIT on drop).
- Changing cfg_threshold mid-extension does not affect the hit in flight.
- req_rdy is never asserted outside IDLE; never more than one bit set.
- stat_issued increments on the ISSUE handshake.
- Counters saturate at 32'hFFFFFFFF.

Optional Feature:
- Macro BLASTN_HIT_SCHED_STATS_EN.
- Defined: stat_issued/stat_dropped are live saturating counters, cleared by reset.
- Undefined: no counter flops; both ports tied to 0.
- Functional behaviour is otherwise identical in both builds.

Decomposition:
- Shared header project/blastn-msgs.v holds:
  - hit_msg_t struct {db_pos,q_pos,db_seq,q_seq}, 128 bits;
  - sched_out_msg_t {db_pos,q_pos,score}, 96 bits;
  - state encodings.
  The same header is reused by the control unit and UGPE.
- One sub-module: project_blastn_rr_arbiter. It is parameterised by NREQ and contains:
  - inputs: req vector, enable;
  - outputs: one-hot grant, grant index;
  - internal pointer, advanced only on enabled grant.
- Line trace prints the state (I/IS/W/E), grant id and score.

Test Plan:
1. Single hit on req 0, threshold 10, UGPE returns 25:
   - ext_req_msg equals the hit at cycle 1;
   - out_msg={db_pos,q_pos,25}, out_id=0;
   - stat_issued=1.
2. Hits on all 4 requesters held valid simultaneously, pointer 0:
   - grants in order 0,1,2,3;
   - a new hit on req 0 then wins after 3.
3. Threshold 100, score 99 then score 100:
   - first dropped, no out_val, stat_dropped=1;
   - second forwarded.
4. Backpressure: ext_req_rdy low 5 cycles, out_rdy low 3 cycles:
   - ext_req_msg/out_msg stable throughout;
   - no req_rdy asserted during stall.
5. Reset asserted asynchronously during WAIT:
   - immediately busy=0, all val/rdy 0, counters 0;
   - after release, next hit on req 2 is granted first (pointer 0, only req 2 valid).
6. cfg_threshold changed 5->200 during WAIT, score 50:
   - hit forwarded using latched threshold 5.
